end_game_banner_fetch: RTL and testbench
========================================

Name: end_game_banner_fetch

Overview:
- Read-side client of the end-game text sprite ROM.
- Maps VGA drawX/drawY into the banner window and issues the ROM select code and pixel address.
- Consumes the ROM's 1-cycle registered 4-bit palette index and delivers an aligned, transparency-filtered pixel to the colour mapper.
- Sequences a per-frame top-down wipe reveal of the banner after game over.

Parameters:
- BANNER_W, 240, banner width in pixels.
- BANNER_H, 120, banner height in rows. BANNER_W*BANNER_H = 28800 = ROM depth.
- ORIGIN_X, 200, screen X of banner's left column.
- ORIGIN_Y, 180, screen Y of banner's top row.
- WIPE_STEP, 4, rows revealed per frame.
- TRANSPARENT_IDX, 4'h0, palette index treated as see-through.
- BLINK_FRAMES, 30, frames per blink phase (optional feature only).

Ports:
- CLK  in  1  pixel-domain clock.
- RESET_N  in  1  asynchronous active-low reset.
- game_over  in  1  level; game has ended.
- winner  in  2  01 = black, 10 = white; 00/11 invalid.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- drawX  in  10  current pixel X.
- drawY  in  10  current pixel Y.
- rom_select  out  2  select to sprite ROM (00 = none, 01 = black, 10 = white).
- rom_addr  out  15  pixel address to sprite ROM.
- rom_data  in  4  ROM palette index, valid 1 cycle after rom_select/rom_addr are sampled.
- pix_valid  out  1  opaque banner pixel present.
- pix_idx  out  4  palette index for the mapper.
- pix_x  out  10  X aligned with pix_*.
- pix_y  out  10  Y aligned with pix_*.
- shown  out  1  wipe complete (state SHOWN).

Behaviour:
- Reset: all outputs 0, state HIDDEN, rows_revealed = 0, latched winner = 00.
- States HIDDEN, WIPE, SHOWN. State changes occur only on cycles with frame_start = 1, so there is no mid-frame tearing.
  - HIDDEN -> WIPE: game_over = 1 and winner is 01 or 10. Winner is latched at this point; later winner changes are ignored. Invalid winner keeps the block in HIDDEN.
  - WIPE: rows_revealed <= min(rows_revealed + WIPE_STEP, BANNER_H), 7-bit saturating. When the new value equals BANNER_H, go to SHOWN.
  - Any state: game_over = 0 at frame_start -> HIDDEN with rows_revealed = 0. This takes priority over all other transitions.
- Hit test, using unsigned 10-bit subtraction:
  - dx = drawX - ORIGIN_X; dy = drawY - ORIGIN_Y.
  - hit = drawX >= ORIGIN_X, dx < BANNER_W, drawY >= ORIGIN_Y, dy < rows_revealed, and state != HIDDEN.
- Pipeline, latency exactly 3 cycles from drawX/drawY to pix_*:
  - Edge 1 registers:
    - rom_addr = dy*BANNER_W + dx (15 bits) if hit, else 0.
    - rom_select = latched winner if hit, else 00.
    - hit, drawX, drawY into stage 1.
  - Edge 2: ROM registers data; stage 1 shifts to stage 2.
  - Edge 3 registers:
    - pix_idx = rom_data.
    - pix_valid = stage 2 hit and rom_data != TRANSPARENT_IDX.
    - pix_x, pix_y = stage 2 coords.
  - When stage 2 hit = 0, pix_valid = 0 and pix_idx = 0. ROM X-data is never propagated.
- Boundaries:
  - Address range is 0..28799; the last pixel (439,299) maps to 28799.
  - rows_revealed never exceeds BANNER_H.
  - Reset mid-pipeline clears all stages immediately.
- shown = registered (state == SHOWN).

Optional Feature:
- Macro: END_BANNER_BLINK_EN.
- Enabled:
  - In SHOWN, a frame counter toggles a visible flag every BLINK_FRAMES frame_starts.
  - While the flag is 0, hit is forced to 0.
  - The flag resets to 1 on entry to SHOWN.
- Disabled: no counter or flag logic; the banner stays steady in SHOWN.

Decomposition:
- Package end_game_pkg:
  - banner_state_t enum {HIDDEN, WIPE, SHOWN}.
  - WIN_BLACK = 2'b01, WIN_WHITE = 2'b10, SEL_NONE = 2'b00.
  - ROM_ADDR_W = 15.
- Sub-module end_game_wipe_ctrl:
  - Holds the state machine, winner latch, rows_revealed and blink logic.
  - Outputs state, rows_revealed and latched winner.
- The top level holds the hit test, address arithmetic and 3-stage pipeline.

Test Plan:
- Reset then idle 2 frames with game_over = 0 -> rom_select = 00, pix_valid = 0, shown = 0 throughout.
- game_over = 1, winner = 11, 3 frame_starts -> stays HIDDEN, rom_select = 00.
- game_over = 1, winner = 01, 1 frame_start:
  - drawY = 183 inside X range -> rom_select = 01.
  - drawY = 184 -> no hit.
  - After 30 frame_starts -> shown = 1, rows_revealed = 120.
- In SHOWN, drive drawX = 439, drawY = 299 -> rom_addr = 28799 at edge 1. With rom_data = 4'h5 -> pix_valid = 1, pix_idx = 5, pix_x = 439 exactly 3 cycles after input.
- In SHOWN, rom_data = TRANSPARENT_IDX -> pix_valid = 0.
- drawX = 199 or 440 -> no hit, rom_addr = 0.
- Drop game_over mid-frame -> banner stays until next frame_start, then HIDDEN. Assert RESET_N = 0 mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/end_game_banner_fetch_pkg.sv
// Shared state encoding, winner/select codes and ROM geometry for the end-game banner fetch.
package end_game_pkg;

   typedef enum logic [1:0] {
      HIDDEN = 2'd0,
      WIPE   = 2'd1,
      SHOWN  = 2'd2
   } banner_state_t;

   localparam logic [1:0] SEL_NONE  = 2'b00;
   localparam logic [1:0] WIN_BLACK = 2'b01;
   localparam logic [1:0] WIN_WHITE = 2'b10;

   localparam int ROM_ADDR_W = 15;

   function automatic logic winner_valid(logic [1:0] w);
      return (w == WIN_BLACK) || (w == WIN_WHITE);
   endfunction

endpackage

// File: rtl/end_game_banner_fetch_if.sv
// Pixel-scan, sprite-ROM and colour-mapper signals of the banner fetch block.
interface end_game_banner_fetch_if;
   import end_game_pkg::*;

   logic                  game_over;
   logic [1:0]            winner;
   logic                  frame_start;
   logic [9:0]            drawX;
   logic [9:0]            drawY;
   logic [1:0]            rom_select;
   logic [ROM_ADDR_W-1:0] rom_addr;
   logic [3:0]            rom_data;
   logic                  pix_valid;
   logic [3:0]            pix_idx;
   logic [9:0]            pix_x;
   logic [9:0]            pix_y;
   logic                  shown;

   modport slave (
      input  game_over, winner, frame_start, drawX, drawY, rom_data,
      output rom_select, rom_addr, pix_valid, pix_idx, pix_x, pix_y, shown
   );

   modport master (
      output game_over, winner, frame_start, drawX, drawY, rom_data,
      input  rom_select, rom_addr, pix_valid, pix_idx, pix_x, pix_y, shown
   );

endinterface

// File: rtl/end_game_banner_fetch_wipe_ctrl.sv
// Banner reveal sequencer: HIDDEN/WIPE/SHOWN, winner latch and revealed-row count.
// Optional blink in SHOWN is built only when END_BANNER_BLINK_EN is defined.
module end_game_wipe_ctrl
   import end_game_pkg::*;
#(
   parameter int unsigned WIPE_STEP    = 4,
   parameter int unsigned BANNER_H     = 120
`ifdef END_BANNER_BLINK_EN
   , parameter int unsigned BLINK_FRAMES = 30
`endif
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          game_over_i,
   input  logic [1:0]    winner_i,
   input  logic          frame_start_i,
   output banner_state_t state_o,
   output logic [6:0]    rows_o,
   output logic [1:0]    winner_o,
   output logic          visible_o,
   output logic          shown_o
);

   localparam logic [7:0] STEP8 = WIPE_STEP[7:0];
   localparam logic [7:0] H8    = BANNER_H[7:0];

   banner_state_t state_q, state_d;
   logic [6:0]    rows_q, rows_d, rows_step;
   logic [1:0]    win_q, win_d;
   logic          shown_q;
   logic [7:0]    rows_sum;

   assign rows_sum  = {1'b0, rows_q} + STEP8;
   assign rows_step = (rows_sum >= H8) ? H8[6:0] : rows_sum[6:0];

   // Everything moves only at frame_start; the first reveal step lands on the
   // same frame_start that starts the wipe.
   always_comb begin
      state_d = state_q;
      rows_d  = rows_q;
      win_d   = win_q;
      if (frame_start_i) begin
         if (!game_over_i) begin
            state_d = HIDDEN;
            rows_d  = '0;
         end else begin
            case (state_q)
               HIDDEN: begin
                  if (winner_valid(winner_i)) begin
                     win_d   = winner_i;
                     rows_d  = rows_step;
                     state_d = (rows_step == H8[6:0]) ? SHOWN : WIPE;
                  end
               end
               WIPE: begin
                  rows_d = rows_step;
                  if (rows_step == H8[6:0]) state_d = SHOWN;
               end
               SHOWN:   state_d = SHOWN;
               default: begin
                  state_d = HIDDEN;
                  rows_d  = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= HIDDEN;
         rows_q  <= '0;
         win_q   <= SEL_NONE;
         shown_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rows_q  <= rows_d;
         win_q   <= win_d;
         shown_q <= (state_d == SHOWN);
      end
   end

`ifdef END_BANNER_BLINK_EN
   localparam int unsigned    BCW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

   logic [BCW-1:0] blink_cnt_q;
   logic           vis_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         blink_cnt_q <= '0;
         vis_q       <= 1'b1;
      end else if (state_d == SHOWN && state_q != SHOWN) begin
         blink_cnt_q <= '0;
         vis_q       <= 1'b1;
      end else if (frame_start_i && state_q == SHOWN && state_d == SHOWN) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            vis_q       <= ~vis_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   assign visible_o = vis_q;
`else
   assign visible_o = 1'b1;
`endif

   assign state_o  = state_q;
   assign rows_o   = rows_q;
   assign winner_o = win_q;
   assign shown_o  = shown_q;

endmodule

// File: rtl/end_game_banner_fetch.sv
// Banner window hit test, sprite-ROM addressing and 3-stage pixel pipeline to the colour mapper.
// Optional feature macro: END_BANNER_BLINK_EN (blinking banner once fully shown).
module end_game_banner_fetch
   import end_game_pkg::*;
#(
   parameter int unsigned BANNER_W        = 240,
   parameter int unsigned BANNER_H        = 120,
   parameter int unsigned ORIGIN_X        = 200,
   parameter int unsigned ORIGIN_Y        = 180,
   parameter int unsigned WIPE_STEP       = 4,
   parameter logic [3:0]  TRANSPARENT_IDX = 4'h0
`ifdef END_BANNER_BLINK_EN
   , parameter int unsigned BLINK_FRAMES  = 30
`endif
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   end_game_banner_fetch_if.slave bus
);

   localparam logic [9:0]            OX   = ORIGIN_X[9:0];
   localparam logic [9:0]            OY   = ORIGIN_Y[9:0];
   localparam logic [9:0]            BW10 = BANNER_W[9:0];
   localparam logic [ROM_ADDR_W-1:0] BW15 = BANNER_W[ROM_ADDR_W-1:0];

   banner_state_t state;
   logic [6:0]    rows;
   logic [1:0]    win_lat;
   logic          visible;
   logic          shown;

   end_game_wipe_ctrl #(
      .WIPE_STEP    (WIPE_STEP),
      .BANNER_H     (BANNER_H)
`ifdef END_BANNER_BLINK_EN
      , .BLINK_FRAMES (BLINK_FRAMES)
`endif
   ) u_wipe_ctrl (
      .clk_i         (CLK),
      .rst_ni        (RESET_N),
      .game_over_i   (bus.game_over),
      .winner_i      (bus.winner),
      .frame_start_i (bus.frame_start),
      .state_o       (state),
      .rows_o        (rows),
      .winner_o      (win_lat),
      .visible_o     (visible),
      .shown_o       (shown)
   );

   // Unsigned wrap makes dx/dy huge left/above the window, so the >= tests
   // are kept explicit rather than relying on the wrap alone.
   logic [9:0]            dx, dy;
   logic                  hit;
   logic [ROM_ADDR_W-1:0] addr_c;

   assign dx  = bus.drawX - OX;
   assign dy  = bus.drawY - OY;
   assign hit = (bus.drawX >= OX) && (dx < BW10) &&
                (bus.drawY >= OY) && (dy < {3'b000, rows}) &&
                (state != HIDDEN) && visible;

   // A hit bounds dy below BANNER_H, so its low 7 bits carry the full row.
   assign addr_c = (ROM_ADDR_W'(dy[6:0]) * BW15) + ROM_ADDR_W'(dx);

   logic [ROM_ADDR_W-1:0] rom_addr_q;
   logic [1:0]            rom_sel_q;
   logic [2:1]            vld_pipe_q;
   logic [2:1][9:0]       x_pipe_q, y_pipe_q;
   logic                  pix_valid_q;
   logic [3:0]            pix_idx_q;
   logic [9:0]            pix_x_q, pix_y_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rom_addr_q  <= '0;
         rom_sel_q   <= SEL_NONE;
         vld_pipe_q  <= '0;
         x_pipe_q    <= '0;
         y_pipe_q    <= '0;
         pix_valid_q <= 1'b0;
         pix_idx_q   <= 4'h0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
      end else begin
         rom_addr_q  <= hit ? addr_c : '0;
         rom_sel_q   <= hit ? win_lat : SEL_NONE;
         vld_pipe_q  <= {vld_pipe_q[1], hit};
         x_pipe_q[1] <= bus.drawX;
         y_pipe_q[1] <= bus.drawY;
         x_pipe_q[2] <= x_pipe_q[1];
         y_pipe_q[2] <= y_pipe_q[1];
         // rom_data is meaningless without a stage-2 hit; never let it through.
         pix_valid_q <= vld_pipe_q[2] && (bus.rom_data != TRANSPARENT_IDX);
         pix_idx_q   <= vld_pipe_q[2] ? bus.rom_data : 4'h0;
         pix_x_q     <= x_pipe_q[2];
         pix_y_q     <= y_pipe_q[2];
      end
   end

   assign bus.rom_addr   = rom_addr_q;
   assign bus.rom_select = rom_sel_q;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.pix_idx    = pix_idx_q;
   assign bus.pix_x      = pix_x_q;
   assign bus.pix_y      = pix_y_q;
   assign bus.shown      = shown;

endmodule

// File: tb/tb_end_game_banner_fetch.sv
// Self-checking bench for end_game_banner_fetch: directed table, corner sequences and random frames vs a reference model.
module tb_end_game_banner_fetch;

   localparam int BW = 240, BH = 120, OXB = 200, OYB = 180, STEP = 4;

   logic CLK = 1'b0;
   logic RESET_N;
   always #5 CLK = ~CLK;

   end_game_banner_fetch_if bus ();

   end_game_banner_fetch dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       v;
      logic [3:0] idx;
      logic [9:0] x;
      logic [9:0] y;
   } pix_t;

   typedef struct {
      int x; int y; int rom; int sel; int addr; int v; int idx;
   } vec_t;

   pix_t       exp_q[$];
   bit         m_active;
   int         m_rows;
   logic [1:0] m_win;
   int         fs_age;
   bit         rom_ovr_en;
   logic [3:0] rom_ovr_val;

   // Sprite ROM stand-in: arbitrary content with some transparent pixels,
   // junk when unselected, or a forced value for directed vectors.
   function automatic logic [3:0] rom_content(logic [1:0] sel, logic [14:0] addr);
      if (rom_ovr_en) return rom_ovr_val;
      if (sel == 2'b00) return 4'hA ^ addr[3:0];
      return 4'((int'(addr) * 7 + int'(sel) * 3) % 16);
   endfunction

   always @(posedge CLK) bus.rom_data <= rom_content(bus.rom_select, bus.rom_addr);

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_rows   = 0;
      m_win    = 2'b00;
   endtask

   task automatic prime();
      pix_t z;
      z.v = 1'b0; z.idx = 4'h0; z.x = '0; z.y = '0;
      exp_q.delete();
      exp_q.push_back(z);
      exp_q.push_back(z);
      fs_age = 10;
   endtask

   task automatic model_frame(input bit go, input logic [1:0] w);
      if (!go) begin
         m_active = 1'b0;
         m_rows   = 0;
      end else if (!m_active) begin
         if (w == 2'b01 || w == 2'b10) begin
            m_active = 1'b1;
            m_win    = w;
            m_rows   = (STEP > BH) ? BH : STEP;
         end
      end else begin
         m_rows = (m_rows + STEP > BH) ? BH : m_rows + STEP;
      end
   endtask

   // One clock: predict from current inputs/model, advance, compare after the edge.
   task automatic tick();
      int x, y;
      logic h;
      logic [1:0] esel;
      logic [14:0] eaddr;
      logic [3:0] rv;
      pix_t e, g;
      x = int'(bus.drawX);
      y = int'(bus.drawY);
      h = m_active && x >= OXB && x < OXB + BW && y >= OYB && y < OYB + m_rows;
      esel  = h ? m_win : 2'b00;
      eaddr = h ? 15'((y - OYB) * BW + (x - OXB)) : 15'd0;
      rv    = rom_content(esel, eaddr);
      e.v   = h && (rv != 4'h0);
      e.idx = h ? rv : 4'h0;
      e.x   = bus.drawX;
      e.y   = bus.drawY;
      exp_q.push_back(e);
      if (bus.frame_start) begin
         model_frame(bus.game_over, bus.winner);
         fs_age = 0;
      end else begin
         fs_age++;
      end
      @(posedge CLK);
      #1;
      g = exp_q.pop_front();
      chk("rom_select", int'(bus.rom_select), int'(esel));
      chk("rom_addr",   int'(bus.rom_addr),   int'(eaddr));
      chk("pix_valid",  int'(bus.pix_valid),  int'(g.v));
      chk("pix_idx",    int'(bus.pix_idx),    int'(g.idx));
      chk("pix_x",      int'(bus.pix_x),      int'(g.x));
      chk("pix_y",      int'(bus.pix_y),      int'(g.y));
      if (fs_age >= 2) chk("shown", int'(bus.shown), int'(m_active && m_rows == BH));
   endtask

   task automatic run_frame(input int n);
      for (int i = 0; i < n; i++) begin
         bus.drawX = 10'($urandom_range(190, 450));
         bus.drawY = 10'($urandom_range(170, 310));
         tick();
      end
      bus.frame_start = 1'b1;
      bus.drawX = '0;
      bus.drawY = '0;
      tick();
      bus.frame_start = 1'b0;
   endtask

   task automatic probe(input string name, input int x, input int y, input int exp_sel);
      bus.drawX = 10'(x);
      bus.drawY = 10'(y);
      tick();
      chk(name, int'(bus.rom_select), exp_sel);
   endtask

   vec_t vt[10];

   initial begin
      vt[0] = '{439, 299,  5, 1, 28799, 1,  5};
      vt[1] = '{200, 180,  7, 1,     0, 1,  7};
      vt[2] = '{439, 180,  3, 1,   239, 1,  3};
      vt[3] = '{200, 299,  9, 1, 28560, 1,  9};
      vt[4] = '{300, 250,  0, 1, 16900, 0,  0};
      vt[5] = '{199, 250,  5, 0,     0, 0,  0};
      vt[6] = '{440, 250,  5, 0,     0, 0,  0};
      vt[7] = '{320, 179,  5, 0,     0, 0,  0};
      vt[8] = '{320, 300,  5, 0,     0, 0,  0};
      vt[9] = '{320, 240, 15, 1, 14520, 1, 15};

      RESET_N = 1'b0;
      bus.game_over = 1'b0; bus.winner = 2'b00; bus.frame_start = 1'b0;
      bus.drawX = '0; bus.drawY = '0;
      rom_ovr_en = 1'b0; rom_ovr_val = 4'h0;
      model_reset();
      fs_age = 10;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_rom_select", int'(bus.rom_select), 0);
      chk("rst_rom_addr",   int'(bus.rom_addr),   0);
      chk("rst_pix_valid",  int'(bus.pix_valid),  0);
      chk("rst_pix_idx",    int'(bus.pix_idx),    0);
      chk("rst_pix_x",      int'(bus.pix_x),      0);
      chk("rst_shown",      int'(bus.shown),      0);
      @(negedge CLK);
      RESET_N = 1'b1;
      prime();

      repeat (2) run_frame(40);

      bus.game_over = 1'b1; bus.winner = 2'b11;
      repeat (3) run_frame(40);
      probe("invalid_winner_sel", 300, 200, 0);

      bus.winner = 2'b01;
      run_frame(20);
      bus.winner = 2'b10;
      probe("row3_hit",  300, 183, 1);
      probe("row4_miss", 300, 184, 0);

      repeat (28) run_frame(20);
      probe("rows116_in",  300, 295, 1);
      probe("rows116_out", 300, 296, 0);
      chk("not_shown_at_116", int'(bus.shown), 0);
      run_frame(20);
      bus.drawX = '0; bus.drawY = '0;
      tick(); tick();
      chk("shown_after_30", int'(bus.shown), 1);

      for (int i = 0; i < 10; i++) begin
         rom_ovr_en  = 1'b1;
         rom_ovr_val = 4'(vt[i].rom);
         bus.drawX = 10'(vt[i].x);
         bus.drawY = 10'(vt[i].y);
         tick();
         chk($sformatf("vec%0d_sel", i),  int'(bus.rom_select), vt[i].sel);
         chk($sformatf("vec%0d_addr", i), int'(bus.rom_addr),   vt[i].addr);
         bus.drawX = '0; bus.drawY = '0;
         tick();
         chk($sformatf("vec%0d_early", i), int'(bus.pix_x), 0);
         tick();
         chk($sformatf("vec%0d_valid", i), int'(bus.pix_valid), vt[i].v);
         chk($sformatf("vec%0d_idx", i),   int'(bus.pix_idx),   vt[i].idx);
         chk($sformatf("vec%0d_x", i),     int'(bus.pix_x),     vt[i].x);
         chk($sformatf("vec%0d_y", i),     int'(bus.pix_y),     vt[i].y);
      end
      rom_ovr_en = 1'b0;

      bus.game_over = 1'b0;
      probe("drop_hold_sel", 300, 200, 1);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      probe("drop_hidden_sel", 300, 200, 0);
      tick();
      chk("drop_not_shown", int'(bus.shown), 0);

      for (int f = 0; f < 30; f++) begin
         bus.game_over = ($urandom_range(0, 15) != 0);
         bus.winner    = 2'($urandom_range(0, 3));
         run_frame(30);
      end

      bus.game_over = 1'b1; bus.winner = 2'b10;
      repeat (3) run_frame(10);
      bus.drawX = 10'd250; bus.drawY = 10'd181;
      tick();
      chk("pre_reset_hit", int'(bus.rom_select != 2'b00), 1);
      tick(); tick();
      #2 RESET_N = 1'b0;
      #1;
      chk("midreset_rom_select", int'(bus.rom_select), 0);
      chk("midreset_rom_addr",   int'(bus.rom_addr),   0);
      chk("midreset_pix_valid",  int'(bus.pix_valid),  0);
      chk("midreset_pix_idx",    int'(bus.pix_idx),    0);
      chk("midreset_pix_x",      int'(bus.pix_x),      0);
      chk("midreset_pix_y",      int'(bus.pix_y),      0);
      chk("midreset_shown",      int'(bus.shown),      0);
      @(negedge CLK);
      RESET_N = 1'b1;
      model_reset();
      prime();
      bus.winner = 2'b01;
      repeat (3) run_frame(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
